// File: rtl/soft_processor_spi_pkg.sv
// soft_processor_spi_pkg: register map, status/control bit positions and SPI slave states
package soft_processor_spi_pkg;
   localparam logic [2:0] ADDR_RXDATA  = 3'd0;
   localparam logic [2:0] ADDR_TXDATA  = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;
   localparam logic [2:0] ADDR_EOP     = 3'd6;
   localparam int ST_EOP  = 9;
   localparam int ST_E    = 8;
   localparam int ST_RRDY = 7;
   localparam int ST_TRDY = 6;
   localparam int ST_TMT  = 5;
   localparam int ST_TOE  = 4;
   localparam int ST_ROE  = 3;
   localparam logic [15:0] IRQ_MASK = 16'h03D8;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_state_t;
endpackage

// File: rtl/soft_processor_spi_sync.sv
// soft_processor_spi_sync: multi-flop synchronizer with one-cycle rise/fall pulses
module soft_processor_spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] chain;
   logic prev;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         prev  <= chain[STAGES-1];
      end
   end
   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/soft_processor_spi_slave.sv
// soft_processor_spi_slave: mode-0 SPI slave with the master's register map on the soft-processor bus
module soft_processor_spi_slave
   import soft_processor_spi_pkg::*;
#(
   parameter int DATABITS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] data_from_cpu,
   input  logic [2:0]  mem_addr,
   input  logic        read_n,
   input  logic        write_n,
   input  logic        spi_select,
   output logic [15:0] data_to_cpu,
   output logic        irq,
   output logic        dataavailable,
   output logic        readyfordata,
   output logic        endofpacket,
   input  logic        SCLK,
   input  logic        SS_n,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_oe
);
   logic unused_sclk, unused_ss_rise, unused_mosi_rise, unused_mosi_fall;
   logic sclk_rise, sclk_fall, ss_sync, ss_fall, mosi_sync;
   spi_state_t state;
   logic [4:0] bitcnt;
   logic [DATABITS-1:0] rx_shift, tx_shift, rx_holding, tx_holding, eop_value, rx_next;
   logic [15:0] control, status;
   logic rd_strobe, wr_strobe, rrdy, roe, toe, eop, tx_primed, underrun;
   logic rd_p1, wr_p1, txw, stw, rd_clear, load, shift_rise, word_done, tx_ok, underrun_toe, new_eop;

   soft_processor_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .reset_n(reset_n), .d(SCLK), .q(unused_sclk), .rise(sclk_rise), .fall(sclk_fall));
   soft_processor_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
      .clk(clk), .reset_n(reset_n), .d(SS_n), .q(ss_sync), .rise(unused_ss_rise), .fall(ss_fall));
   soft_processor_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .reset_n(reset_n), .d(MOSI), .q(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

   assign rd_p1        = ~rd_strobe & spi_select & ~read_n;
   assign wr_p1        = ~wr_strobe & spi_select & ~write_n;
   assign txw          = wr_p1 & (mem_addr == ADDR_TXDATA);
   assign stw          = wr_p1 & (mem_addr == ADDR_STATUS);
   assign rd_clear     = rd_strobe & (mem_addr == ADDR_RXDATA);
   assign load         = (state == LOAD) & ~ss_sync;
   assign shift_rise   = (state == SHIFT) & ~ss_sync & sclk_rise;
   assign word_done    = shift_rise & (bitcnt == 5'(DATABITS-1));
   assign underrun_toe = shift_rise & underrun & (bitcnt == '0);
   assign rx_next      = DATABITS'({rx_shift, mosi_sync});
   // a LOAD in the same cycle frees the holding register before the write is judged
   assign tx_ok        = txw & (~tx_primed | load);
   assign new_eop      = (word_done & (rx_next == eop_value)) | (txw & (data_from_cpu[DATABITS-1:0] == eop_value));

   assign dataavailable = rrdy;
   assign readyfordata  = ~tx_primed;
   assign endofpacket   = eop;
   assign MISO          = ~ss_sync & tx_shift[DATABITS-1];
   assign MISO_oe       = ~ss_sync;

   always_comb begin
      status          = '0;
      status[ST_EOP]  = eop;
      status[ST_E]    = roe | toe;
      status[ST_RRDY] = rrdy;
      status[ST_TRDY] = ~tx_primed;
      status[ST_TMT]  = ~tx_primed & ss_sync;
      status[ST_TOE]  = toe;
      status[ST_ROE]  = roe;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         bitcnt      <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         rx_holding  <= '0;
         tx_holding  <= '0;
         eop_value   <= '0;
         control     <= '0;
         data_to_cpu <= '0;
         irq         <= 1'b0;
         rd_strobe   <= 1'b0;
         wr_strobe   <= 1'b0;
         rrdy        <= 1'b0;
         roe         <= 1'b0;
         toe         <= 1'b0;
         eop         <= 1'b0;
         tx_primed   <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         rd_strobe   <= rd_p1;
         wr_strobe   <= wr_p1;
         data_to_cpu <= mem_addr == ADDR_RXDATA  ? 16'(rx_holding) :
                        mem_addr == ADDR_STATUS  ? status :
                        mem_addr == ADDR_CONTROL ? control :
                        mem_addr == ADDR_EOP     ? 16'(eop_value) : '0;
         irq         <= |(status & control & IRQ_MASK);
         control     <= (wr_p1 && mem_addr == ADDR_CONTROL) ? data_from_cpu : control;
         eop_value   <= (wr_p1 && mem_addr == ADDR_EOP) ? data_from_cpu[DATABITS-1:0] : eop_value;
         tx_holding  <= tx_ok ? data_from_cpu[DATABITS-1:0] : tx_holding;
         tx_primed   <= tx_ok | (tx_primed & ~load);
         rx_holding  <= word_done ? rx_next : rx_holding;
         rrdy        <= word_done | (rrdy & ~rd_clear & ~stw);
         roe         <= (word_done & rrdy & ~rd_clear) | (roe & ~stw);
         toe         <= (txw & ~tx_ok) | underrun_toe | (toe & ~stw);
         eop         <= new_eop | (eop & ~stw);
         if (ss_sync) begin
            state    <= IDLE;
            bitcnt   <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            underrun <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= ss_fall ? LOAD : IDLE;
               LOAD: begin
                  tx_shift <= tx_primed ? tx_holding : '0;
                  underrun <= ~tx_primed;
                  bitcnt   <= '0;
                  state    <= SHIFT;
               end
               SHIFT: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_next;
                     bitcnt   <= bitcnt + 5'd1;
                     underrun <= underrun & (bitcnt != '0);
                  end
                  if (sclk_fall) begin
                     if (bitcnt == 5'(DATABITS)) state <= LOAD;
                     else tx_shift <= tx_shift << 1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
